// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter slice.
//   state_t         : arbiter FSM encoding (also exported on dbg_state)
//   GNT_IF / GNT_D  : requester identifiers used for grants and last_grant
//   DEFAULT_N       : default data/address width
package mem_port_arbiter_pkg;

  localparam int DEFAULT_N = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-input round-robin picker.
//   req[1:0]   : in  requests, indexed by grant id (bit GNT_IF, bit GNT_D)
//   last_grant : in  id granted most recently
//   gnt_valid  : out at least one request present
//   gnt_id     : out id to grant; on a tie, the one not granted last time
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = GNT_IF;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[GNT_D]) begin
      gnt_id = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch requester and
// the load/store requester, one transaction at a time, with a timeout watchdog.
//
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   if_req/if_addr                   : fetch request (held until if_ack)
//   if_rdata/if_ack                  : fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata        : load/store request (held until d_ack)
//   d_rdata/d_ack                    : load data, one-cycle completion pulse
//   err                              : qualifies the ack pulse; 1 = timed out
//   mem_req/mem_we/mem_addr/mem_wdata: memory strobe and command
//   mem_rdata/mem_ready              : memory response, sampled only while mem_req=1
//   dbg_state                        : current FSM state
//
// Handshake: a requester raises x_req with its command and keeps it high; the
// command is sampled only in the grant cycle; completion is the single-cycle
// x_ack, with err telling success (0) from timeout (1). The memory side sees
// mem_req held high with a stable command until one cycle with mem_ready=1.
//
// All outputs are registered. The cycle carrying an ack is a turnaround cycle
// in which no new grant is made, so a requester can react to its ack before
// being re-arbitrated; back-to-back accesses therefore take 3 cycles each.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [31:0]  if_rdata,
  output logic         if_ack,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_ack,
  output logic         err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output state_t       dbg_state
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mem_req_nxt, mem_we_nxt;
  logic [N-1:0]  mem_addr_nxt, mem_wdata_nxt, d_rdata_nxt;
  logic [31:0]   if_rdata_nxt;
  logic          if_ack_nxt, d_ack_nxt, err_nxt;
  logic          gnt_valid, gnt_id;
  logic          turnaround;

  assign turnaround = if_ack | d_ack;
  assign dbg_state  = state;

  arb_rr2 u_arb (
    .req        ({d_req, if_req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
    if_ack_nxt     = 1'b0;
    d_ack_nxt      = 1'b0;
    err_nxt        = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_valid && !turnaround) begin
          last_grant_nxt = gnt_id;
          cnt_nxt        = '0;
          mem_req_nxt    = 1'b1;
          if (gnt_id == GNT_D) begin
            state_nxt     = BUSY_D;
            mem_addr_nxt  = d_addr;
            mem_we_nxt    = d_we;
            mem_wdata_nxt = d_wdata;
          end else begin
            state_nxt     = BUSY_IF;
            mem_addr_nxt  = if_addr;
            mem_we_nxt    = 1'b0;
            mem_wdata_nxt = '0;
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        // mem_ready is checked first so it wins over an expiring watchdog.
        if (mem_ready || cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          err_nxt     = ~mem_ready;
          if (state == BUSY_IF) begin
            if_ack_nxt = 1'b1;
            if (!mem_ready) begin
              if_rdata_nxt = '0;
            end else if (mem_addr[2]) begin
              if_rdata_nxt = mem_rdata[63:32];
            end else begin
              if_rdata_nxt = mem_rdata[31:0];
            end
          end else begin
            d_ack_nxt = 1'b1;
            if (!mem_ready) begin
              d_rdata_nxt = '0;
            end else if (!mem_we) begin
              d_rdata_nxt = mem_rdata;
            end
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      if_ack     <= if_ack_nxt;
      d_ack      <= d_ack_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a long randomized run,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N       = 64;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         if_req, d_req, d_we;
  logic [N-1:0] if_addr, d_addr, d_wdata;
  logic [31:0]  if_rdata;
  logic         if_ack, d_ack, err;
  logic [N-1:0] d_rdata;
  logic         mem_req, mem_we, mem_ready;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
  state_t       dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] exp_q[$];
  logic         cmp_en = 1'b0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  // resp_mode: 0 random latency (occasionally never), 1 fixed latency, 2 never.
  logic [N-1:0] mem_store [logic [N-1:0]];
  int           resp_mode   = 1;
  int           fixed_delay = 0;
  logic         stray_en    = 1'b0;
  logic         force_pulse = 1'b0;
  int           hi_cnt      = 0;
  int           cur_delay   = 0;

  function automatic logic [N-1:0] mem_read(input logic [N-1:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  always @(posedge clk) begin
    #2;
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (mem_req === 1'b1) begin
      if (hi_cnt == 0) begin
        if (resp_mode == 1)      cur_delay = fixed_delay;
        else if (resp_mode == 2) cur_delay = 1000;
        else if ($urandom_range(0, 7) == 0) cur_delay = 40;
        else cur_delay = $urandom_range(0, 3);
      end
      hi_cnt++;
      if (hi_cnt - 1 >= cur_delay) begin
        mem_ready = 1'b1;
        if (mem_we) mem_store[mem_addr] = mem_wdata;
        else        mem_rdata = mem_read(mem_addr);
      end
    end else begin
      hi_cnt = 0;
      if (force_pulse || (stray_en && $urandom_range(0, 7) == 0)) mem_ready = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Tracks the one transaction in flight: who owns it, what it asked for,
  // and how many cycles the memory has been kept waiting.
  logic         m_busy, m_owner, m_last, m_store, m_turn;
  int           m_waited;
  logic         m_mem_req, m_mem_we, m_if_ack, m_d_ack, m_err;
  logic [N-1:0] m_addr, m_wdata, m_d_rdata;
  logic [31:0]  m_if_rdata;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_owner = GNT_IF; m_last = GNT_D; m_store = 0; m_waited = 0;
      m_mem_req = 0; m_mem_we = 0; m_if_ack = 0; m_d_ack = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_d_rdata = '0; m_if_rdata = '0;
    end else begin
      m_turn   = m_if_ack | m_d_ack;
      m_if_ack = 0; m_d_ack = 0; m_err = 0;
      if (m_busy) begin
        m_waited++;
        if (mem_ready || m_waited == TIMEOUT) begin
          m_busy = 0; m_mem_req = 0; m_mem_we = 0;
          m_err  = !mem_ready;
          if (m_owner == GNT_D) begin
            m_d_ack = 1;
            if (!mem_ready)    m_d_rdata = '0;
            else if (!m_store) m_d_rdata = mem_rdata;
          end else begin
            m_if_ack   = 1;
            m_if_rdata = !mem_ready ? 32'h0 : (m_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]);
          end
        end
      end else if (!m_turn && (if_req || d_req)) begin
        m_owner   = (if_req && d_req) ? ~m_last : d_req;
        m_last    = m_owner;
        m_busy    = 1;
        m_waited  = 0;
        m_mem_req = 1;
        m_store   = (m_owner == GNT_D) ? d_we : 1'b0;
        m_mem_we  = m_store;
        m_addr    = (m_owner == GNT_D) ? d_addr : if_addr;
        m_wdata   = (m_owner == GNT_D) ? d_wdata : '0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("if_ack",   if_ack,   m_if_ack);
      check("d_ack",    d_ack,    m_d_ack);
      check("err",      err,      m_err);
      check("mem_req",  mem_req,  m_mem_req);
      check("if_rdata", if_rdata, m_if_rdata);
      check("d_rdata",  d_rdata,  m_d_rdata);
      check("state",    dbg_state, !m_busy ? IDLE : (m_owner == GNT_D ? BUSY_D : BUSY_IF));
      if (m_mem_req) begin
        check("mem_we",    mem_we,    m_mem_we);
        check("mem_addr",  mem_addr,  m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- driver / directed scenarios ----------------
  initial begin
    int   hi, cyc, last_cyc, acks;
    logic got;
    reset = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_store[64'h104] = 64'hAAAA_BBBB_1111_2222;
    step();
    cmp_en = 1'b1;
    step(); step();
    check("rst_mem_req", mem_req, 0);
    check("rst_if_ack",  if_ack, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_state",   dbg_state, IDLE);
    reset = 0;
    step();

    // single fetch, memory answers in the first mem_req cycle
    if_req = 1; if_addr = 64'h104;
    step();
    check("fetch_mem_req",  mem_req, 1);
    check("fetch_mem_addr", mem_addr, 64'h104);
    check("fetch_mem_we",   mem_we, 0);
    step();
    check("fetch_ack",   if_ack, 1);
    check("fetch_rdata", if_rdata, 64'hAAAA_BBBB);
    check("fetch_err",   err, 0);
    if_req = 0;
    step(); step();

    // store then load of the same doubleword
    d_req = 1; d_we = 1; d_addr = 64'h40; d_wdata = 64'h1234;
    step();
    check("store_mem_we",    mem_we, 1);
    check("store_mem_wdata", mem_wdata, 64'h1234);
    check("store_mem_addr",  mem_addr, 64'h40);
    step();
    check("store_ack", d_ack, 1);
    check("store_err", err, 0);
    d_req = 0; d_we = 0;
    step();
    d_req = 1; d_addr = 64'h40; d_wdata = 64'hDEAD;
    step();
    check("load_mem_we", mem_we, 0);
    step();
    check("load_ack",   d_ack, 1);
    check("load_rdata", d_rdata, 64'h1234);
    d_req = 0;
    step();

    // continuous contention from reset: IF, D, IF, D ... every 3 cycles
    reset = 1; if_req = 1; d_req = 1; d_we = 0; if_addr = 64'h8; d_addr = 64'h10;
    step(); step();
    reset = 0;
    repeat (3) begin exp_q.push_back(N'(GNT_IF)); exp_q.push_back(N'(GNT_D)); end
    cyc = 0; last_cyc = -1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      step(); cyc++;
      if (if_ack || d_ack) begin
        check("cont_single_ack", if_ack & d_ack, 0);
        check("cont_order", d_ack, exp_q.pop_front());
        if (last_cyc >= 0) check("cont_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
      end
    end
    check("cont_all_served", exp_q.size(), 0);
    if_req = 0; d_req = 0;
    step(); step();

    // timeout: memory never answers
    resp_mode = 2;
    d_req = 1; d_we = 0; d_addr = 64'h80;
    hi = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (d_ack) begin got = 1; break; end
      if (mem_req) hi++;
    end
    check("to_acked",      got, 1);
    check("to_req_cycles", hi, TIMEOUT);
    check("to_err",        err, 1);
    check("to_rdata",      d_rdata, 0);
    d_req = 0;
    step(); step();
    force_pulse = 1;
    step();
    force_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_late_ready_ignored", if_ack | d_ack, 0);
    end

    // mem_ready arrives in the last watchdog cycle: ready wins
    resp_mode = 1; fixed_delay = TIMEOUT - 1;
    d_req = 1; d_we = 0; d_addr = 64'h40;
    hi = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (d_ack) begin got = 1; break; end
      if (mem_req) hi++;
    end
    check("tie_acked",      got, 1);
    check("tie_req_cycles", hi, TIMEOUT);
    check("tie_err",        err, 0);
    check("tie_rdata",      d_rdata, 64'h1234);
    d_req = 0;
    step(); step();

    // reset two cycles into BUSY_D
    resp_mode = 2;
    d_req = 1; d_addr = 64'h48;
    step(); step();
    reset = 1; d_req = 0;
    step();
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_ack",     d_ack, 0);
    check("rst_mid_state",   dbg_state, IDLE);
    reset = 0;
    force_pulse = 1;
    step();
    force_pulse = 0;
    step();
    check("rst_mid_late_ready", if_ack | d_ack, 0);
    resp_mode = 1; fixed_delay = 0;
    if_req = 1; d_req = 1; if_addr = 64'h4; d_addr = 64'h48;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if_ack || d_ack) begin got = 1; break; end
    end
    check("rst_tie_acked", got, 1);
    check("rst_tie_is_if", if_ack, 1);
    check("rst_tie_not_d", d_ack, 0);
    if_req = 0; d_req = 0;
    step(); step();

    // randomized traffic
    resp_mode = 0; stray_en = 1; acks = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) if_req = ~if_req;
      if ($urandom_range(0, 9) == 0) d_req = ~d_req;
      if ($urandom_range(0, 3) == 0) if_addr = N'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) begin
        d_addr  = N'($urandom_range(0, 15)) << 3;
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = {$urandom, $urandom};
      end
      reset = ($urandom_range(0, 499) == 0);
      step();
      if (if_ack || d_ack) acks++;
    end
    check("rand_progress", acks > 100, 1);
    reset = 0; if_req = 0; d_req = 0; stray_en = 0;
    repeat (25) step();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
